// File: rtl/interrupt_sequencer.sv
// Reset / IRQ / NMI entry sequencer: pushes PC and P, then fetches the vector and reloads PC.
// Define INTERRUPT_SEQUENCER_NMI_EN to enable the NMI path; without it nmi_n is ignored.
module interrupt_sequencer (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        irq_n,
  input  logic        nmi_n,
  input  logic        i_flag,
  input  logic        instr_boundary,
  output logic        normal,
  output logic        flush,
  output logic        busy,
  output logic        push_en,
  output logic [1:0]  push_sel,
  output logic        vec_rd,
  output logic [15:0] vec_addr,
  output logic        pc_load_lo,
  output logic        pc_load_hi,
  output logic        set_i
);

  typedef enum logic [3:0] {
    RST0, RST1, RST2, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI
  } state_t;

  typedef enum logic [1:0] {SRC_NMI, SRC_IRQ, SRC_RESET} src_t;

  state_t      state, state_nxt;
  src_t        src, src_nxt;
  logic [1:0]  irq_sync;
  logic        nmi_pending;
  logic        normal_d, flush_d, push_en_d, vec_rd_d, pc_lo_d, pc_hi_d, set_i_d;
  logic [1:0]  push_sel_d;
  logic [15:0] vec_base;

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) irq_sync <= '1;
    else     irq_sync <= {irq_sync[0], irq_n};
  end

`ifdef INTERRUPT_SEQUENCER_NMI_EN
  logic [2:0] nmi_sync;  // [0] meta, [1] synchronised, [2] previous synchronised
  logic       nmi_edge, nmi_clear;

  assign nmi_edge  = nmi_sync[2] & ~nmi_sync[1];
  assign nmi_clear = (state == PUSH_P) && (src == SRC_NMI);

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      nmi_sync    <= '1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_sync    <= {nmi_sync[1:0], nmi_n};
      nmi_pending <= nmi_edge | (nmi_pending & ~nmi_clear);
    end
  end
`else
  logic unused_nmi;
  assign unused_nmi  = nmi_n;
  assign nmi_pending = 1'b0;
`endif

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state <= RST0;
      src   <= SRC_RESET;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    case (state)
      RST0:     state_nxt = RST1;
      RST1:     state_nxt = RST2;
      RST2:     state_nxt = VEC_LO;
      IDLE: begin
        if (instr_boundary && (nmi_pending || (!irq_sync[1] && !i_flag))) begin
          state_nxt = PUSH_PCH;
          src_nxt   = nmi_pending ? SRC_NMI : SRC_IRQ;
        end
      end
      PUSH_PCH: state_nxt = PUSH_PCL;
      PUSH_PCL: state_nxt = PUSH_P;
      PUSH_P:   state_nxt = VEC_LO;
      VEC_LO:   state_nxt = VEC_HI;
      VEC_HI:   state_nxt = IDLE;
      default:  state_nxt = RST0;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state register.
  always_comb begin
    normal_d   = 1'b0;
    flush_d    = 1'b0;
    push_en_d  = 1'b0;
    push_sel_d = '0;
    vec_rd_d   = 1'b0;
    pc_lo_d    = 1'b0;
    pc_hi_d    = 1'b0;
    set_i_d    = 1'b0;
    case (state_nxt)
      RST0:     flush_d = 1'b1;
      IDLE:     normal_d = 1'b1;
      PUSH_PCH: begin flush_d = 1'b1; push_en_d = 1'b1; push_sel_d = 2'd0; end
      PUSH_PCL: begin push_en_d = 1'b1; push_sel_d = 2'd1; end
      PUSH_P:   begin push_en_d = 1'b1; push_sel_d = 2'd2; end
      VEC_LO:   begin vec_rd_d = 1'b1; pc_lo_d = 1'b1; set_i_d = 1'b1; end
      VEC_HI:   begin vec_rd_d = 1'b1; pc_hi_d = 1'b1; end
      default:  ;
    endcase
    case (src_nxt)
`ifdef INTERRUPT_SEQUENCER_NMI_EN
      SRC_NMI:   vec_base = 16'hFFFA;
`endif
      SRC_RESET: vec_base = 16'hFFFC;
      default:   vec_base = 16'hFFFE;
    endcase
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      normal     <= 1'b0;
      flush      <= 1'b1;
      busy       <= 1'b1;
      push_en    <= 1'b0;
      push_sel   <= '0;
      vec_rd     <= 1'b0;
      vec_addr   <= 16'hFFFC;
      pc_load_lo <= 1'b0;
      pc_load_hi <= 1'b0;
      set_i      <= 1'b0;
    end else begin
      normal     <= normal_d;
      flush      <= flush_d;
      busy       <= ~normal_d;
      push_en    <= push_en_d;
      push_sel   <= push_sel_d;
      vec_rd     <= vec_rd_d;
      vec_addr   <= {vec_base[15:1], state_nxt == VEC_HI};
      pc_load_lo <= pc_lo_d;
      pc_load_hi <= pc_hi_d;
      set_i      <= set_i_d;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus random stimulus against a queue-driven phase model.
`timescale 1ns/1ps
module tb_interrupt_sequencer;

  logic        clk_2 = 1'b0;
  logic        rst, irq_n, nmi_n, i_flag, instr_boundary;
  logic        normal, flush, busy, push_en, vec_rd, pc_load_lo, pc_load_hi, set_i;
  logic [1:0]  push_sel;
  logic [15:0] vec_addr;

  interrupt_sequencer dut (
    .clk_2(clk_2), .rst(rst), .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag),
    .instr_boundary(instr_boundary), .normal(normal), .flush(flush), .busy(busy),
    .push_en(push_en), .push_sel(push_sel), .vec_rd(vec_rd), .vec_addr(vec_addr),
    .pc_load_lo(pc_load_lo), .pc_load_hi(pc_load_hi), .set_i(set_i)
  );

  always #5 clk_2 = ~clk_2;

`ifdef INTERRUPT_SEQUENCER_NMI_EN
  localparam bit NMI_ON = 1'b1;
`else
  localparam bit NMI_ON = 1'b0;
`endif

  typedef enum int {P_IDLE, P_R0, P_R1, P_R2, P_PCH, P_PCL, P_P, P_VLO, P_VHI} phase_e;
  // vector address = FFFA + 2*slot
  localparam int SLOT_NMI = 0, SLOT_RESET = 1, SLOT_IRQ = 2;

  phase_e m_cur;
  phase_e m_todo[$];
  int     m_slot;
  bit     m_pend;
  bit     irq_hist[$];  // input samples from the last two edges, oldest first
  bit     nmi_hist[$];  // last three edges, oldest first
  int     checks = 0, passed = 0;

  function automatic void model_reset();
    m_cur    = P_R0;
    m_todo   = {P_R1, P_R2, P_VLO, P_VHI};
    m_slot   = SLOT_RESET;
    m_pend   = 1'b0;
    irq_hist = {1'b1, 1'b1};
    nmi_hist = {1'b1, 1'b1, 1'b1};
  endfunction

  function automatic void model_step();
    bit irq_seen, nmi_fell, clr;
    if (rst) begin
      model_reset();
    end else begin
      irq_seen = !irq_hist[0];
      nmi_fell = nmi_hist[0] && !nmi_hist[1];
      clr      = 1'b0;
      if (m_cur == P_IDLE) begin
        if (instr_boundary && (m_pend || (irq_seen && !i_flag))) begin
          m_slot = m_pend ? SLOT_NMI : SLOT_IRQ;
          m_cur  = P_PCH;
          m_todo = {P_PCL, P_P, P_VLO, P_VHI};
        end
      end else if (m_todo.size() != 0) begin
        m_cur = m_todo.pop_front();
        clr   = (m_cur == P_VLO) && (m_slot == SLOT_NMI);
      end else begin
        m_cur = P_IDLE;
      end
      m_pend = NMI_ON && (nmi_fell || (m_pend && !clr));
      irq_hist.push_back(irq_n);
      void'(irq_hist.pop_front());
      nmi_hist.push_back(nmi_n);
      void'(nmi_hist.pop_front());
    end
  endfunction

  // {normal, flush, busy, push_en, push_sel, vec_rd, pc_load_lo, pc_load_hi, set_i}
  function automatic logic [9:0] exp_ctl(phase_e p);
    case (p)
      P_IDLE:     return 10'b1_0_0_0_00_0_0_0_0;
      P_R0:       return 10'b0_1_1_0_00_0_0_0_0;
      P_R1, P_R2: return 10'b0_0_1_0_00_0_0_0_0;
      P_PCH:      return 10'b0_1_1_1_00_0_0_0_0;
      P_PCL:      return 10'b0_0_1_1_01_0_0_0_0;
      P_P:        return 10'b0_0_1_1_10_0_0_0_0;
      P_VLO:      return 10'b0_0_1_0_00_1_1_0_1;
      P_VHI:      return 10'b0_0_1_0_00_1_0_1_0;
      default:    return 10'b0;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [9:0]  obs, exp;
    logic [15:0] ea;
    obs = {normal, flush, busy, push_en, push_sel, vec_rd, pc_load_lo, pc_load_hi, set_i};
    exp = exp_ctl(m_cur);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s ctl phase=%s observed=%b expected=%b", tag, m_cur.name(), obs, exp);
    if (m_cur inside {P_R0, P_VLO, P_VHI}) begin
      ea = 16'hFFFA + 16'(2 * m_slot) + ((m_cur == P_VHI) ? 16'd1 : 16'd0);
      checks++;
      assert (vec_addr === ea) passed++;
      else $error("FAIL %s vec_addr phase=%s observed=%h expected=%h", tag, m_cur.name(), vec_addr, ea);
    end
  endtask

  // Drive inputs away from the edge, advance one clock, then check on the falling edge.
  task automatic tick(input bit r, input bit irq, input bit nmi, input bit fi, input bit ib,
                      input string tag);
    rst = r; irq_n = irq; nmi_n = nmi; i_flag = fi; instr_boundary = ib;
    if (r) begin
      model_reset();
      #1;
      check({tag, "_async"});
    end
    @(posedge clk_2);
    model_step();
    @(negedge clk_2);
    check(tag);
  endtask

  initial begin
    bit irq_v, nmi_v;
    rst = 1'b1; irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b0; instr_boundary = 1'b0;
    model_reset();
    @(negedge clk_2);
    check("reset_hold");
    repeat (2) tick(1, 1, 1, 0, 0, "reset_hold");

    // reset sequence runs to IDLE
    repeat (7) tick(0, 1, 1, 0, 1, "reset_seq");

    // IRQ taken with I clear
    repeat (3) tick(0, 0, 1, 0, 0, "irq_setup");
    tick(0, 0, 1, 0, 1, "irq_take");
    repeat (6) tick(0, 1, 1, 0, 0, "irq_seq");

    // IRQ masked by I
    repeat (6) tick(0, 0, 1, 1, 1, "irq_masked");
    repeat (3) tick(0, 1, 1, 0, 0, "irq_release");

    // NMI and IRQ before the same boundary: NMI first, IRQ at the following one
    repeat (3) tick(0, 0, 0, 0, 0, "nmi_irq_setup");
    tick(0, 0, 0, 0, 1, "nmi_irq_take");
    repeat (5) tick(0, 0, 0, 0, 0, "nmi_seq");
    tick(0, 0, 0, 0, 1, "irq_after_nmi");
    repeat (6) tick(0, 1, 1, 0, 0, "irq_after_nmi_seq");

    // NMI edge while an IRQ sequence is in PUSH_PCL
    repeat (2) tick(0, 0, 1, 0, 0, "irq2_setup");
    tick(0, 0, 1, 0, 1, "irq2_take");
    for (int k = 0; k < 4 && m_cur != P_PCL; k++) tick(0, 1, 1, 0, 0, "irq2_wait");
    tick(0, 1, 0, 0, 0, "nmi_in_pcl");
    repeat (5) tick(0, 1, 0, 0, 0, "irq2_finish");
    tick(0, 1, 0, 0, 1, "nmi_late_take");
    repeat (6) tick(0, 1, 1, 0, 0, "nmi_late_seq");

    // reset pulse during VEC_LO of an IRQ sequence
    repeat (3) tick(0, 0, 1, 0, 0, "irq3_setup");
    tick(0, 0, 1, 0, 1, "irq3_take");
    for (int k = 0; k < 6 && m_cur != P_VLO; k++) tick(0, 1, 1, 0, 0, "irq3_wait");
    tick(1, 1, 1, 0, 0, "rst_in_veclo");
    repeat (7) tick(0, 1, 1, 0, 0, "reset_again");

    irq_v = 1'b1;
    nmi_v = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) irq_v = ~irq_v;
      if ($urandom_range(0, 11) == 0) nmi_v = ~nmi_v;
      tick($urandom_range(0, 79) == 0, irq_v, nmi_v, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, "random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port clk_2  input  1  phase-2 clock; all state changes on posedge clk_2.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port irq_n  input  1  maskable interrupt request, level-sensitive, active-low.
REQ-004 SHALL have port nmi_n  input  1  non-maskable interrupt, falling-edge-sensitive.
REQ-005 SHALL have port i_flag  input  1  interrupt-disable bit from the status register.
REQ-006 SHALL have port instr_boundary  input  1  decoder is in the last micro-step of the current instruction.
REQ-007 SHALL have port normal  output  1  decoder runs normal decode when 1.
REQ-008 SHALL have port flush  output  1  decoder forces the instruction register to NOP (EA).
REQ-009 SHALL have port busy  output  1  a sequence is in progress.
REQ-010 SHALL have port push_en  output  1  write one byte to the stack and decrement the stack pointer.
REQ-011 SHALL have port push_sel  output  2  push source: 0=PCH, 1=PCL, 2=P; 3 is unused.
REQ-012 SHALL have port vec_rd  output  1  read memory at vec_addr.
REQ-013 SHALL have port vec_addr  output  16  vector byte address.
REQ-014 SHALL have port pc_load_lo / pc_load_hi  output  1 each  load the read byte into PCL / PCH.
REQ-015 SHALL have port set_i  output  1  set the I flag.

Function
REQ-016 SHALL implement FSM states RST0, RST1, RST2, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI; all outputs registered and decoded from the state (Moore).
REQ-017 RST0->RST1->RST2->VEC_LO->VEC_HI->IDLE SHALL take one cycle per step; RST states assert no push_en.
REQ-018 nmi_pending SHALL set on a falling edge of nmi_n (irq_n/nmi_n double-flop synchronised; edge detected on the synchronised value).
REQ-019 In IDLE with instr_boundary=1, the FSM SHALL go to PUSH_PCH next cycle if nmi_pending=1, or if synchronised irq_n=0 and i_flag=0; otherwise it SHALL stay in IDLE.
REQ-020 NMI SHALL take priority over IRQ; the serviced source SHALL be latched on entry to PUSH_PCH as src (NMI, IRQ, RESET).
REQ-021 Sequence SHALL be PUSH_PCH->PUSH_PCL->PUSH_P->VEC_LO->VEC_HI->IDLE, 5 cycles; push_en=1 with push_sel 0, 1, 2 respectively.
REQ-022 flush SHALL be 1 only in PUSH_PCH and RST0; normal SHALL be 1 only in IDLE; busy SHALL be the inverse of normal.
REQ-023 vec_addr SHALL be FFFA/FFFB for NMI, FFFC/FFFD for RESET, FFFE/FFFF for IRQ (VEC_LO/VEC_HI); vec_rd=1 in both states.
REQ-024 pc_load_lo and set_i SHALL be 1 in VEC_LO; pc_load_hi SHALL be 1 in VEC_HI.
REQ-025 nmi_pending SHALL clear on entry to VEC_LO when src=NMI; an NMI edge arriving at the same cycle SHALL re-set nmi_pending (set wins).
REQ-026 An NMI edge during any non-IDLE state SHALL stay pending and be serviced at the next instr_boundary in IDLE.
REQ-027 IRQ SHALL NOT be latched; if irq_n deasserts before a boundary it SHALL be ignored.

Reset
REQ-028 While rst=1 the FSM SHALL be held in RST0; outputs: normal=0, flush=1, busy=1, push_en=0, push_sel=0, vec_rd=0, vec_addr=FFFC, pc_load_lo=0, pc_load_hi=0, set_i=0; nmi_pending=0; synchronisers=1.
REQ-029 Assertion of rst mid-sequence SHALL abort it immediately and restart the reset sequence from RST0 on release.

Configuration
REQ-030 With macro INTERRUPT_SEQUENCER_NMI_EN defined, REQ-018/020/025/026 SHALL apply.
REQ-031 Without INTERRUPT_SEQUENCER_NMI_EN, nmi_n SHALL be ignored, nmi_pending SHALL be absent (constant 0), and FFFA/FFFB SHALL never be driven.

Verification
REQ-032 Release rst -> 3 cycles with no push_en, then vec_addr FFFC with pc_load_lo, FFFD with pc_load_hi, then normal=1.
REQ-033 irq_n=0, i_flag=0, instr_boundary=1 in IDLE -> flush 1 cycle, push_sel 0,1,2, vec_addr FFFE, FFFF, set_i=1, normal=1 after 5 cycles.
REQ-034 irq_n=0, i_flag=1, instr_boundary=1 -> FSM stays IDLE, normal stays 1, no push_en.
REQ-035 NMI falling edge and irq_n=0 before the same boundary -> vector FFFA/FFFB; IRQ (still low, i_flag=0 before set_i) serviced at the following boundary.
REQ-036 NMI edge during PUSH_PCL of an IRQ sequence -> IRQ completes at FFFE; the next boundary starts an NMI sequence at FFFA.
REQ-037 rst pulsed during VEC_LO of an IRQ sequence -> outputs return to the REQ-028 values at once; the RESET sequence runs at FFFC.
